// File: rtl/mac_pkg.sv
// Shared definitions for the FP16 MAC wrapper: operand width, FP16 word type
// and the operand feeder state encoding.
package mac_pkg;

   localparam int DATA_W = 16;

   typedef logic [DATA_W-1:0] fp16_t;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_CLEAR  = 2'd1,
      FS_STREAM = 2'd2,
      FS_DONE   = 2'd3
   } feeder_state_e;

endpackage : mac_pkg

// File: rtl/operand_buffer.sv
// Operand pair storage for the MAC feeder: DEPTH entries of {A,B}, one
// synchronous write port and one asynchronous read port. Storage is not reset;
// the feeder only reads entries it has written since the last DONE or reset.
module operand_buffer #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the accepted load beat into the addressed entry.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule : operand_buffer

// File: rtl/mac_operand_feeder.sv
// Upstream stage of the FP16 MAC wrapper. Collects up to DEPTH (A,B) pairs
// from a valid/ready port, then on start issues a one-cycle accumulator clear
// followed by one pair per cycle (stallable by hold), and pulses done after
// the last pair. Operands are passed through bit-exact.
module mac_operand_feeder #(
   parameter  int DATA_W = mac_pkg::DATA_W,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              start,
   input  logic              hold,
   output logic              mac_clr,
   output logic              mac_en,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count
);

   import mac_pkg::*;

   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE_C = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1);

   feeder_state_e       state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic                all_issued_q, all_issued_d;
   logic                mac_clr_q, mac_clr_d;
   logic                mac_en_q, mac_en_d;
   logic [DATA_W-1:0]   mac_a_q, mac_a_d;
   logic [DATA_W-1:0]   mac_b_q, mac_b_d;
   logic                done_q, done_d;

   logic                buf_we;
   logic [2*DATA_W-1:0] rd_data;
   logic                beat_accept;
   logic                last_pair;

   operand_buffer #(
      .WIDTH (2*DATA_W),
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (wr_ptr_q),
      .wr_data ({in_a, in_b}),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   // Loading is only possible in IDLE with room left; a start request takes
   // priority over a beat presented in the same cycle.
   assign in_ready    = (state_q == FS_IDLE) && (count_q < DEPTH_C) && !start;
   assign beat_accept = in_valid && in_ready;

   // The pair at rd_ptr is the final one of this dot product.
   assign last_pair   = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE_C));

   // Sequencer: next state, pointer/count updates and next output values.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      all_issued_d = all_issued_q;
      mac_clr_d    = 1'b0;
      mac_en_d     = 1'b0;
      mac_a_d      = mac_a_q;
      mac_b_d      = mac_b_q;
      done_d       = 1'b0;
      buf_we       = 1'b0;

      case (state_q)
         FS_IDLE: begin
            if (start && (count_q != {(ADDR_W+1){1'b0}})) begin
               state_d      = FS_CLEAR;
               mac_clr_d    = 1'b1;
               rd_ptr_d     = {ADDR_W{1'b0}};
               all_issued_d = 1'b0;
            end else if (beat_accept) begin
               buf_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE_C;
               count_d  = count_q + CNT_ONE_C;
            end else begin
               state_d = FS_IDLE;
            end
         end

         FS_CLEAR: begin
            // The first pair is queued while the clear is on the bus.
            state_d      = FS_STREAM;
            mac_en_d     = 1'b1;
            mac_a_d      = rd_data[2*DATA_W-1:DATA_W];
            mac_b_d      = rd_data[DATA_W-1:0];
            rd_ptr_d     = rd_ptr_q + PTR_ONE_C;
            all_issued_d = last_pair;
         end

         FS_STREAM: begin
            if (all_issued_q) begin
               state_d = FS_DONE;
               done_d  = 1'b1;
               mac_a_d = {DATA_W{1'b0}};
               mac_b_d = {DATA_W{1'b0}};
            end else if (hold) begin
               mac_en_d = 1'b0;
            end else begin
               mac_en_d     = 1'b1;
               mac_a_d      = rd_data[2*DATA_W-1:DATA_W];
               mac_b_d      = rd_data[DATA_W-1:0];
               rd_ptr_d     = rd_ptr_q + PTR_ONE_C;
               all_issued_d = last_pair;
            end
         end

         FS_DONE: begin
            state_d      = FS_IDLE;
            count_d      = {(ADDR_W+1){1'b0}};
            wr_ptr_d     = {ADDR_W{1'b0}};
            rd_ptr_d     = {ADDR_W{1'b0}};
            all_issued_d = 1'b0;
         end

         default: begin
            state_d      = FS_IDLE;
            count_d      = {(ADDR_W+1){1'b0}};
            wr_ptr_d     = {ADDR_W{1'b0}};
            rd_ptr_d     = {ADDR_W{1'b0}};
            all_issued_d = 1'b0;
            mac_a_d      = {DATA_W{1'b0}};
            mac_b_d      = {DATA_W{1'b0}};
         end
      endcase
   end

   // State, pointer, count and output registers; reset aborts any sequence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FS_IDLE;
         count_q      <= {(ADDR_W+1){1'b0}};
         wr_ptr_q     <= {ADDR_W{1'b0}};
         rd_ptr_q     <= {ADDR_W{1'b0}};
         all_issued_q <= 1'b0;
         mac_clr_q    <= 1'b0;
         mac_en_q     <= 1'b0;
         mac_a_q      <= {DATA_W{1'b0}};
         mac_b_q      <= {DATA_W{1'b0}};
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         all_issued_q <= all_issued_d;
         mac_clr_q    <= mac_clr_d;
         mac_en_q     <= mac_en_d;
         mac_a_q      <= mac_a_d;
         mac_b_q      <= mac_b_d;
         done_q       <= done_d;
      end
   end

   assign mac_clr = mac_clr_q;
   assign mac_en  = mac_en_q;
   assign mac_a   = mac_a_q;
   assign mac_b   = mac_b_q;
   assign done    = done_q;
   assign busy    = (state_q == FS_CLEAR) || (state_q == FS_STREAM);
   assign count   = count_q;

endmodule : mac_operand_feeder

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder. A queue holds the pairs the
// feeder should have buffered; each streaming run is checked against that
// queue and the documented clear/enable/done latencies.
module tb_mac_operand_feeder;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          start;
   logic          hold;
   logic          mac_clr;
   logic          mac_en;
   logic [DW-1:0] mac_a;
   logic [DW-1:0] mac_b;
   logic          busy;
   logic          done;
   logic [AW:0]   count;

   int n_cmp;
   int n_bad;
   int cyc;

   logic [31:0] model[$];

   mac_operand_feeder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .start    (start),
      .hold     (hold),
      .mac_clr  (mac_clr),
      .mac_en   (mac_en),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .busy     (busy),
      .done     (done),
      .count    (count)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency checks.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for one cycle; the model takes it only if there is room.
   task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit room;
      room     = (model.size() < DEPTH);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      #1;
      chk("load_ready", {31'd0, in_ready}, {31'd0, room});
      tick();
      in_valid = 1'b0;
      #1;
      if (room) model.push_back({a, b});
      chk("load_count", {28'd0, count}, model.size());
   endtask

   task automatic idle_outputs_zero(input string tag);
      chk({tag, "_clr"},  {31'd0, mac_clr}, 32'd0);
      chk({tag, "_en"},   {31'd0, mac_en},  32'd0);
      chk({tag, "_busy"}, {31'd0, busy},    32'd0);
      chk({tag, "_done"}, {31'd0, done},    32'd0);
   endtask

   // Start a dot product over the model queue and check the whole sequence.
   // Directed hold: hold_len cycles once hold_after pairs have been issued.
   task automatic do_stream(input int hold_after, input int hold_len,
                            input bit rand_hold, input bit beat_too);
      int          n, t, h, issued, budget, hcnt;
      bit          prev_hold;
      logic [31:0] p;
      logic [15:0] last_a, last_b;
      n      = model.size();
      last_a = 16'd0;
      last_b = 16'd0;
      start  = 1'b1;
      if (beat_too) begin
         in_valid = 1'b1;
         in_a     = 16'($urandom);
         in_b     = 16'($urandom);
      end
      #1;
      chk("start_ready", {31'd0, in_ready}, 32'd0);
      t = cyc;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("clr_pulse", {31'd0, mac_clr}, 32'd1);
      chk("clr_busy",  {31'd0, busy},    32'd1);
      chk("clr_en",    {31'd0, mac_en},  32'd0);
      chk("clr_a",     {16'd0, mac_a},   32'd0);
      chk("clr_count", {28'd0, count},   n);
      hold = rand_hold ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      issued    = 0;
      h         = 0;
      hcnt      = 0;
      prev_hold = 1'b0;
      budget    = 0;
      while (issued < n && budget < 4 * DEPTH + 16) begin
         chk("stream_en",    {31'd0, mac_en},   {31'd0, !prev_hold});
         chk("stream_busy",  {31'd0, busy},     32'd1);
         chk("stream_clr",   {31'd0, mac_clr},  32'd0);
         chk("stream_ready", {31'd0, in_ready}, 32'd0);
         if (!prev_hold) begin
            p      = model[issued];
            last_a = p[31:16];
            last_b = p[15:0];
            issued++;
         end
         chk("stream_a", {16'd0, mac_a}, {16'd0, last_a});
         chk("stream_b", {16'd0, mac_b}, {16'd0, last_b});
         if (rand_hold) begin
            hold = ($urandom_range(0, 2) == 0);
         end else begin
            hold = (issued == hold_after) && (hcnt < hold_len);
            if (hold) hcnt++;
         end
         prev_hold = hold && (issued < n);
         if (prev_hold) h++;
         budget++;
         tick();
      end
      if (issued < n) chk("stream_timeout", issued, n);
      hold = 1'b0;
      #1;
      chk("done_pulse", {31'd0, done},   32'd1);
      chk("done_cycle", cyc - t,         2 + n + h);
      chk("done_en",    {31'd0, mac_en}, 32'd0);
      chk("done_a",     {16'd0, mac_a},  32'd0);
      chk("done_b",     {16'd0, mac_b},  32'd0);
      chk("done_busy",  {31'd0, busy},   32'd0);
      chk("done_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("post_done",  {31'd0, done},     32'd0);
      chk("post_ready", {31'd0, in_ready}, 32'd1);
      chk("post_count", {28'd0, count},    32'd0);
      model.delete();
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_a     = 16'd0;
      in_b     = 16'd0;
      start    = 1'b0;
      hold     = 1'b0;
      tick();
      tick();
      idle_outputs_zero("reset");
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_count", {28'd0, count},    32'd0);
      chk("reset_a",     {16'd0, mac_a},    32'd0);
      reset = 1'b0;
      tick();

      // Directed three-pair dot product.
      send_beat(16'h3C00, 16'h4000);
      send_beat(16'h4200, 16'h4400);
      send_beat(16'h3800, 16'h3800);
      do_stream(0, 0, 1'b0, 1'b0);

      // Fill the buffer, then a ninth beat must stall.
      for (int i = 0; i < DEPTH; i++) send_beat(16'(16'h1000 + i), 16'(16'h2000 + i));
      in_valid = 1'b1;
      in_a     = 16'hDEAD;
      in_b     = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_ready", {31'd0, in_ready}, 32'd0);
         chk("full_count", {28'd0, count},    DEPTH);
         tick();
      end
      in_valid = 1'b0;
      do_stream(0, 0, 1'b0, 1'b0);

      // start with an empty buffer is ignored.
      start = 1'b1;
      #1;
      chk("empty_start_ready", {31'd0, in_ready}, 32'd0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         idle_outputs_zero("empty_start");
         chk("empty_start_idle", {31'd0, in_ready}, 32'd1);
         tick();
      end

      // Two-cycle hold after the second of four pairs.
      for (int i = 0; i < 4; i++) send_beat(16'($urandom), 16'($urandom));
      do_stream(2, 2, 1'b0, 1'b0);

      // start and in_valid together: the beat is rejected.
      send_beat(16'h1111, 16'h2222);
      send_beat(16'h3333, 16'h4444);
      do_stream(0, 0, 1'b0, 1'b1);

      // Reset in the middle of streaming.
      for (int i = 0; i < 4; i++) send_beat(16'($urandom), 16'($urandom));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      idle_outputs_zero("midreset");
      chk("midreset_a",     {16'd0, mac_a},    32'd0);
      chk("midreset_b",     {16'd0, mac_b},    32'd0);
      chk("midreset_ready", {31'd0, in_ready}, 32'd1);
      chk("midreset_count", {28'd0, count},    32'd0);
      model.delete();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         idle_outputs_zero("after_reset");
      end

      // Randomised runs: random lengths, data, load gaps and holds.
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_beat(16'($urandom), 16'($urandom));
         end
         do_stream(0, 0, 1'b1, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mac_operand_feeder
